// File: rtl/rc4_core_scheduler.sv
// rc4_core_scheduler: hands candidate RC4 keys to a bank of cracking cores in
// round-robin order, tracks per-core busy state and stops on the first success
// or once the whole key space has been handed out and finished.
module rc4_core_scheduler #(
  parameter int unsigned          NUM_CORES = 4,
  parameter int unsigned          KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [NUM_CORES-1:0] core_start,
  output logic [KEY_WIDTH-1:0] core_key,
  output logic                 core_abort,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_success,
  output logic                 found,
  output logic                 failed,
  output logic                 stop,
  output logic [KEY_WIDTH-1:0] found_key,
  output logic [NUM_CORES-1:0] busy
);

  localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StFound = 3'd3;
  localparam logic [2:0] StFail  = 3'd4;

  // One extra bit so the counter can step past an all-ones KEY_MAX without wrapping.
  localparam logic [KEY_WIDTH:0] KeyLast = {1'b0, KEY_MAX};

  logic [2:0]           state_q;
  logic                 warm_q;      // first RUN cycle is dispatch-free
  logic [KEY_WIDTH:0]   next_key_q;
  logic [IdxW-1:0]      rr_q;
  logic [NUM_CORES-1:0] busy_q;
  logic [KEY_WIDTH-1:0] key_reg_q [NUM_CORES];
  logic                 found_q;
  logic                 failed_q;
  logic                 stop_q;
  logic [KEY_WIDTH-1:0] found_key_q;

  logic [NUM_CORES-1:0] qual;
  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] busy_clr;
  logic                 any_hit;
  logic [IdxW-1:0]      win_idx;
  logic                 free_ok;
  logic [IdxW-1:0]      free_idx;
  logic [IdxW-1:0]      cand;
  logic [IdxW-1:0]      rr_next;
  logic                 dispatch;

  // Qualify done pulses with busy and pick the lowest-index successful core.
  always_comb begin
    qual     = core_done & busy_q;
    hit      = qual & core_success;
    busy_clr = busy_q & ~qual;
    any_hit  = |hit;
    win_idx  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit[i]) win_idx = IdxW'(i);
    end
  end

  // Circular search for an idle core starting at rr_q, then drive the dispatch.
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = IdxW'((32'(rr_q) + k) % NUM_CORES);
      if (!free_ok && !busy_q[cand]) begin
        free_ok  = 1'b1;
        free_idx = cand;
      end
    end
    dispatch   = (state_q == StRun) && warm_q && !any_hit && free_ok &&
                 (next_key_q <= KeyLast);
    core_start = '0;
    if (dispatch) core_start[free_idx] = 1'b1;
    core_key   = dispatch ? next_key_q[KEY_WIDTH-1:0] : '0;
    rr_next    = (free_idx == IdxW'(NUM_CORES - 1)) ? '0 : free_idx + 1'b1;
  end

  // Search state, busy tracking, key bookkeeping and sticky result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      warm_q      <= 1'b0;
      next_key_q  <= '0;
      rr_q        <= '0;
      busy_q      <= '0;
      found_q     <= 1'b0;
      failed_q    <= 1'b0;
      stop_q      <= 1'b0;
      found_key_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) key_reg_q[i] <= '0;
    end else begin
      stop_q <= (state_q == StFound) || (state_q == StFail);
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            warm_q  <= 1'b0;
          end
        end
        StRun, StDrain: begin
          warm_q <= 1'b1;
          if (any_hit) begin
            found_q     <= 1'b1;
            found_key_q <= key_reg_q[win_idx];
            busy_q      <= '0;
            state_q     <= StFound;
          end else begin
            busy_q <= busy_clr | core_start;
            if (dispatch) begin
              key_reg_q[free_idx] <= core_key;
              rr_q                <= rr_next;
              next_key_q          <= next_key_q + 1'b1;
              if (next_key_q == KeyLast) state_q <= StDrain;
            end
            if ((state_q == StDrain) && (busy_clr == '0)) begin
              failed_q <= 1'b1;
              state_q  <= StFail;
            end
          end
        end
        StFound: busy_q <= '0;
        default: ;
      endcase
    end
  end

  assign core_abort = (state_q == StFound);
  assign found      = found_q;
  assign failed     = failed_q;
  assign stop       = stop_q;
  assign found_key  = found_key_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rc4_core_scheduler.sv
// Scoreboard bench for rc4_core_scheduler: the expected key sequence is queued
// at search start and popped on each dispatch; a small core model returns done
// pulses after a programmable latency and tracks the expected result flags.
module tb_rc4_core_scheduler;

  localparam int NC   = 4;
  localparam int KW   = 8;
  localparam int KMAX = 255;

  logic          clk;
  logic          reset;
  logic          start;
  logic [NC-1:0] core_start;
  logic [KW-1:0] core_key;
  logic          core_abort;
  logic [NC-1:0] core_done;
  logic [NC-1:0] core_success;
  logic          found;
  logic          failed;
  logic          stop;
  logic [KW-1:0] found_key;
  logic [NC-1:0] busy;

  rc4_core_scheduler #(
    .NUM_CORES(NC),
    .KEY_WIDTH(KW),
    .KEY_MAX  (8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .core_start  (core_start),
    .core_key    (core_key),
    .core_abort  (core_abort),
    .core_done   (core_done),
    .core_success(core_success),
    .found       (found),
    .failed      (failed),
    .stop        (stop),
    .found_key   (found_key),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int q[$];
  int tmr[NC];
  int mkey[NC];
  int mrr;
  int lat, slow_key, slow_lat, win_a, win_b;
  bit live, spur_req, spur_fired;
  bit e_found, e_failed, e_stop;
  int e_fkey;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check registered outputs, drive core responses, check dispatch.
  task automatic step();
    logic [NC-1:0] mb;
    int            exp_j, j, hk, e;
    bit            hit_any, exp_disp, all_idle, stop_n;
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) mb[i] = (tmr[i] != 0);
    chk("busy", busy, mb);
    chk("found", found, e_found);
    chk("failed", failed, e_failed);
    chk("stop", stop, e_stop);
    chk("abort", core_abort, e_found);
    chk("found_key", found_key, e_found ? e_fkey : 0);
    if (spur_fired) begin
      chk("spur_ignored", found, 0);
      spur_fired = 0;
    end
    core_done    = '0;
    core_success = '0;
    hit_any      = 0;
    hk           = 0;
    for (int i = 0; i < NC; i++) begin
      if (tmr[i] == 1) begin
        core_done[i] = 1'b1;
        if (mkey[i] == win_a || mkey[i] == win_b) begin
          core_success[i] = 1'b1;
          if (!hit_any) begin
            hit_any = 1;
            hk      = mkey[i];
          end
        end
        tmr[i] = 0;
      end else if (tmr[i] > 1) begin
        tmr[i]--;
      end
    end
    if (spur_req && live && !mb[2]) begin
      core_done[2]    = 1'b1;
      core_success[2] = 1'b1;
      spur_req        = 0;
      spur_fired      = 1;
    end
    exp_j = -1;
    for (int k = 0; k < NC; k++) begin
      j = (mrr + k) % NC;
      if (exp_j < 0 && !mb[j]) exp_j = j;
    end
    exp_disp = live && !e_found && !hit_any && (q.size() > 0) && (exp_j >= 0);
    #1;
    if (exp_disp) begin
      e = q.pop_front();
      chk("core_start", core_start, 1 << exp_j);
      chk("core_key", core_key, e);
      tmr[exp_j]  = (e == slow_key) ? slow_lat : lat;
      mkey[exp_j] = e;
      mrr         = (exp_j + 1) % NC;
    end else begin
      chk("no_start", core_start, 0);
    end
    stop_n = e_found | e_failed;
    if (hit_any) begin
      e_found = 1;
      e_fkey  = hk;
      q.delete();
      for (int i = 0; i < NC; i++) tmr[i] = 0;
    end
    all_idle = 1;
    for (int i = 0; i < NC; i++) if (tmr[i] != 0) all_idle = 0;
    if (live && !e_found && q.size() == 0 && all_idle) e_failed = 1;
    e_stop = stop_n;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    live  = 0;
    q.delete();
    for (int i = 0; i < NC; i++) begin
      tmr[i]  = 0;
      mkey[i] = 0;
    end
    mrr        = 0;
    e_found    = 0;
    e_failed   = 0;
    e_stop     = 0;
    e_fkey     = 0;
    spur_req   = 0;
    spur_fired = 0;
    step();
    reset = 1'b0;
  endtask

  task automatic begin_search(input int l, input int wa, input int wb, input int sk,
                              input int sl);
    lat      = l;
    win_a    = wa;
    win_b    = wb;
    slow_key = sk;
    slow_lat = sl;
    for (int k = 0; k <= KMAX; k++) q.push_back(k);
    start = 1'b1;
    step();  // transition cycle plus first RUN cycle: no dispatch expected
    start = 1'b0;
    live  = 1;
  endtask

  task automatic run_until_stop(input int budget);
    int n;
    n = 0;
    while (stop !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("stop_reached", stop, 1);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    start        = 1'b0;
    core_done    = '0;
    core_success = '0;
    win_a        = -1;
    win_b        = -1;
    slow_key     = -1;
    slow_lat     = 0;
    lat          = 3;
    do_reset();
    do_reset();

    // Full exhaustion with an all-ones KEY_MAX; long latency forces stalls.
    begin_search(6, -1, -1, -1, 0);
    run_until_stop(2000);
    chk("exh_failed", failed, 1);
    chk("exh_found", found, 0);
    chk("exh_keys_left", q.size(), 0);
    step();
    step();

    // Single winner at 0x2A, with a spurious done+success from idle core 2.
    do_reset();
    spur_req = 1;
    begin_search(3, 'h2A, -1, -1, 0);
    run_until_stop(500);
    chk("win_2a", found_key, 8'h2A);
    chk("win_found", found, 1);
    step();

    // Cores 1 and 3 succeed in the same cycle; lower index must win.
    do_reset();
    begin_search(3, 'h11, 'h13, 'h11, 5);
    run_until_stop(500);
    chk("win_11", found_key, 8'h11);
    step();

    // Reset mid-search with three cores busy, then restart from key 0.
    do_reset();
    begin_search(20, -1, -1, -1, 0);
    step();
    step();
    step();
    step();
    chk("three_busy", busy, 4'b0111);
    do_reset();
    chk("rst_busy", busy, 0);
    begin_search(3, 5, -1, -1, 0);
    run_until_stop(200);
    chk("win_05", found_key, 8'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
